// File: rtl/bus_cycle_sequencer_if.sv
// ---------------------------------------------------------------------------
// bus_cycle_sequencer_if
//   Groups the command channel, the response channel and the 8088-style CPU
//   bus between a command issuer / CHIPSET model and bus_cycle_sequencer.
//
//   Command channel : cmd_valid, cmd_ready, cmd_type, cmd_address, cmd_data,
//                     cmd_lock
//   CPU bus         : processor_ready, cpu_data_bus_in (from CHIPSET),
//                     processor_status, processor_lock_n, cpu_address,
//                     cpu_data_bus_out, cpu_data_bus_oe (to CHIPSET)
//   Response        : rsp_valid, rsp_data, rsp_timeout
//
//   modport slave  : the sequencer side
//   modport master : the side issuing commands and modelling CHIPSET
// ---------------------------------------------------------------------------
interface bus_cycle_sequencer_if #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [2:0]            cmd_type;
  logic [ADDR_WIDTH-1:0] cmd_address;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic                  cmd_lock;
  logic                  processor_ready;
  logic [DATA_WIDTH-1:0] cpu_data_bus_in;
  logic [2:0]            processor_status;
  logic                  processor_lock_n;
  logic [ADDR_WIDTH-1:0] cpu_address;
  logic [DATA_WIDTH-1:0] cpu_data_bus_out;
  logic                  cpu_data_bus_oe;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_timeout;

  modport slave (
    input  cmd_valid, cmd_type, cmd_address, cmd_data, cmd_lock,
           processor_ready, cpu_data_bus_in,
    output cmd_ready, processor_status, processor_lock_n, cpu_address,
           cpu_data_bus_out, cpu_data_bus_oe, rsp_valid, rsp_data, rsp_timeout
  );

  modport master (
    output cmd_valid, cmd_type, cmd_address, cmd_data, cmd_lock,
           processor_ready, cpu_data_bus_in,
    input  cmd_ready, processor_status, processor_lock_n, cpu_address,
           cpu_data_bus_out, cpu_data_bus_oe, rsp_valid, rsp_data, rsp_timeout
  );
endinterface

// File: rtl/bus_cycle_sequencer.sv
// ---------------------------------------------------------------------------
// bus_cycle_sequencer
//   8088 bus-cycle master used for CHIPSET self-test and bring-up. Accepts
//   (type, address, data, lock) commands and replays each one as an S2..S0
//   status bus cycle: status phase, wait states, passive hold, recovery.
//   Returns captured read data or a timeout flag as a one-cycle response.
//
//   Ports
//     clock : system clock
//     reset : synchronous, active-high; drops any command in flight
//     bus   : bus_cycle_sequencer_if.slave (command, CPU bus, response)
//
//   All interface outputs come straight from registers.
// ---------------------------------------------------------------------------
module bus_cycle_sequencer #(
  parameter int ADDR_WIDTH     = 20,
  parameter int DATA_WIDTH     = 8,
  parameter int STATUS_CYCLES  = 4,
  parameter int HOLD_CYCLES    = 1,
  parameter int IDLE_CYCLES    = 1,
  parameter int INTA_GAP       = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                  clock,
  input logic                  reset,
  bus_cycle_sequencer_if.slave bus
);

  localparam logic [2:0] TYPE_INTA  = 3'b000;
  localparam logic [2:0] TYPE_IOR   = 3'b001;
  localparam logic [2:0] TYPE_IOW   = 3'b010;
  localparam logic [2:0] TYPE_HALT  = 3'b011;
  localparam logic [2:0] TYPE_CODE  = 3'b100;
  localparam logic [2:0] TYPE_MEMR  = 3'b101;
  localparam logic [2:0] TYPE_MEMW  = 3'b110;
  localparam logic [2:0] TYPE_DELAY = 3'b111;

  // One phase counter serves ACTIVE, GAP, HOLD and RECOVER.
  localparam int MAX_SH     = (STATUS_CYCLES > HOLD_CYCLES) ? STATUS_CYCLES : HOLD_CYCLES;
  localparam int MAX_IG     = (IDLE_CYCLES > INTA_GAP) ? IDLE_CYCLES : INTA_GAP;
  localparam int PHASE_MAX  = (MAX_SH > MAX_IG) ? MAX_SH : MAX_IG;
  localparam int PHASE_W    = $clog2(PHASE_MAX + 1);
  // Wait counter is at least 8 bits and saturates, so it can never wrap.
  localparam int WAIT_W_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int WAIT_W     = (WAIT_W_RAW > 8) ? WAIT_W_RAW : 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_WAIT,
    ST_GAP,
    ST_HOLD,
    ST_RECOVER
  } state_t;

  function automatic logic is_read(input logic [2:0] t);
    return (t == TYPE_IOR) || (t == TYPE_CODE) || (t == TYPE_MEMR) || (t == TYPE_INTA);
  endfunction

  function automatic logic is_write(input logic [2:0] t);
    return (t == TYPE_IOW) || (t == TYPE_MEMW);
  endfunction

  state_t                state_r, state_s;
  logic [PHASE_W-1:0]    phase_r, phase_s;
  logic [WAIT_W-1:0]     wait_r, wait_s;
  logic                  second_r, second_s;
  logic [2:0]            cmd_type_r, cmd_type_s;
  logic [ADDR_WIDTH-1:0] cmd_addr_r, cmd_addr_s;
  logic [DATA_WIDTH-1:0] cmd_data_r, cmd_data_s;
  logic                  cmd_lock_r, cmd_lock_s;

  logic                  accept_s;
  logic                  no_wait_s;
  state_t                done_state_s;
  logic                  done_rsp_s;
  logic [DATA_WIDTH-1:0] capture_s;

  logic                  cmd_ready_r, cmd_ready_s;
  logic [2:0]            status_r, status_s;
  logic                  lock_n_r, lock_n_s;
  logic [ADDR_WIDTH-1:0] addr_r, addr_s;
  logic [DATA_WIDTH-1:0] dout_r, dout_s;
  logic                  oe_r, oe_s;
  logic                  rsp_valid_r, rsp_valid_s;
  logic [DATA_WIDTH-1:0] rsp_data_r, rsp_data_s;
  logic                  rsp_timeout_r, rsp_timeout_s;

  // Next-state, counters, command latch and response generation.
  always_comb begin
    state_s       = state_r;
    phase_s       = phase_r;
    wait_s        = wait_r;
    second_s      = second_r;
    cmd_type_s    = cmd_type_r;
    cmd_addr_s    = cmd_addr_r;
    cmd_data_s    = cmd_data_r;
    cmd_lock_s    = cmd_lock_r;
    rsp_valid_s   = 1'b0;
    rsp_data_s    = {DATA_WIDTH{1'b0}};
    rsp_timeout_s = 1'b0;

    accept_s  = bus.cmd_valid & cmd_ready_r;
    // HALT and delay cycles never look at ready and never capture.
    no_wait_s = (cmd_type_r == TYPE_HALT) || (cmd_type_r == TYPE_DELAY);
    // The first INTA pulse ends in the passive gap without a response.
    if ((cmd_type_r == TYPE_INTA) && !second_r) begin
      done_state_s = ST_GAP;
      done_rsp_s   = 1'b0;
    end else begin
      done_state_s = ST_HOLD;
      done_rsp_s   = 1'b1;
    end
    if (done_rsp_s && is_read(cmd_type_r)) begin
      capture_s = bus.cpu_data_bus_in;
    end else begin
      capture_s = {DATA_WIDTH{1'b0}};
    end

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s    = ST_ACTIVE;
          phase_s    = {PHASE_W{1'b0}};
          wait_s     = {WAIT_W{1'b0}};
          second_s   = 1'b0;
          cmd_type_s = bus.cmd_type;
          cmd_addr_s = bus.cmd_address;
          cmd_data_s = bus.cmd_data;
          cmd_lock_s = bus.cmd_lock;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (phase_r == PHASE_W'(STATUS_CYCLES - 1)) begin
          phase_s = {PHASE_W{1'b0}};
          if (no_wait_s) begin
            state_s     = ST_HOLD;
            rsp_valid_s = 1'b1;
          end else if (bus.processor_ready) begin
            state_s     = done_state_s;
            rsp_valid_s = done_rsp_s;
            rsp_data_s  = capture_s;
          end else begin
            state_s = ST_WAIT;
            wait_s  = {WAIT_W{1'b0}};
          end
        end else begin
          phase_s = phase_r + PHASE_W'(1);
        end
      end
      ST_WAIT: begin
        if (bus.processor_ready) begin
          state_s     = done_state_s;
          phase_s     = {PHASE_W{1'b0}};
          rsp_valid_s = done_rsp_s;
          rsp_data_s  = capture_s;
        end else if (wait_r >= WAIT_W'(TIMEOUT_CYCLES - 1)) begin
          // This wait cycle is the last allowed one: abort, even mid-INTA.
          state_s       = ST_HOLD;
          phase_s       = {PHASE_W{1'b0}};
          rsp_valid_s   = 1'b1;
          rsp_timeout_s = 1'b1;
        end else if (wait_r != {WAIT_W{1'b1}}) begin
          wait_s = wait_r + WAIT_W'(1);
        end else begin
          wait_s = wait_r;
        end
      end
      ST_GAP: begin
        if (phase_r == PHASE_W'(INTA_GAP - 1)) begin
          state_s  = ST_ACTIVE;
          phase_s  = {PHASE_W{1'b0}};
          second_s = 1'b1;
        end else begin
          phase_s = phase_r + PHASE_W'(1);
        end
      end
      ST_HOLD: begin
        if (phase_r == PHASE_W'(HOLD_CYCLES - 1)) begin
          state_s = ST_RECOVER;
          phase_s = {PHASE_W{1'b0}};
        end else begin
          phase_s = phase_r + PHASE_W'(1);
        end
      end
      ST_RECOVER: begin
        if (phase_r == PHASE_W'(IDLE_CYCLES - 1)) begin
          state_s = ST_IDLE;
          phase_s = {PHASE_W{1'b0}};
        end else begin
          phase_s = phase_r + PHASE_W'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        phase_s = {PHASE_W{1'b0}};
      end
    endcase
  end

  // Bus outputs for the cycle we are about to enter, so they can be registered.
  always_comb begin
    cmd_ready_s = (state_s == ST_IDLE);
    status_s    = 3'b111;
    lock_n_s    = 1'b1;
    addr_s      = {ADDR_WIDTH{1'b0}};
    dout_s      = {DATA_WIDTH{1'b0}};
    oe_s        = 1'b0;
    case (state_s)
      ST_ACTIVE, ST_WAIT: begin
        // Delay's type code is 111, so the status naturally stays passive.
        status_s = cmd_type_s;
        lock_n_s = ~cmd_lock_s;
        addr_s   = cmd_addr_s;
        if (is_write(cmd_type_s)) begin
          dout_s = cmd_data_s;
          oe_s   = 1'b1;
        end else begin
          dout_s = {DATA_WIDTH{1'b0}};
          oe_s   = 1'b0;
        end
      end
      ST_GAP, ST_HOLD: begin
        lock_n_s = ~cmd_lock_s;
        addr_s   = cmd_addr_s;
      end
      default: begin
        status_s = 3'b111;
      end
    endcase
  end

  // State, counters and latched command.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      phase_r    <= {PHASE_W{1'b0}};
      wait_r     <= {WAIT_W{1'b0}};
      second_r   <= 1'b0;
      cmd_type_r <= 3'b111;
      cmd_addr_r <= {ADDR_WIDTH{1'b0}};
      cmd_data_r <= {DATA_WIDTH{1'b0}};
      cmd_lock_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      phase_r    <= phase_s;
      wait_r     <= wait_s;
      second_r   <= second_s;
      cmd_type_r <= cmd_type_s;
      cmd_addr_r <= cmd_addr_s;
      cmd_data_r <= cmd_data_s;
      cmd_lock_r <= cmd_lock_s;
    end
  end

  // Output registers; reset returns the bus to passive at once.
  always_ff @(posedge clock) begin
    if (reset) begin
      cmd_ready_r   <= 1'b0;
      status_r      <= 3'b111;
      lock_n_r      <= 1'b1;
      addr_r        <= {ADDR_WIDTH{1'b0}};
      dout_r        <= {DATA_WIDTH{1'b0}};
      oe_r          <= 1'b0;
      rsp_valid_r   <= 1'b0;
      rsp_data_r    <= {DATA_WIDTH{1'b0}};
      rsp_timeout_r <= 1'b0;
    end else begin
      cmd_ready_r   <= cmd_ready_s;
      status_r      <= status_s;
      lock_n_r      <= lock_n_s;
      addr_r        <= addr_s;
      dout_r        <= dout_s;
      oe_r          <= oe_s;
      rsp_valid_r   <= rsp_valid_s;
      rsp_data_r    <= rsp_data_s;
      rsp_timeout_r <= rsp_timeout_s;
    end
  end

  assign bus.cmd_ready        = cmd_ready_r;
  assign bus.processor_status = status_r;
  assign bus.processor_lock_n = lock_n_r;
  assign bus.cpu_address      = addr_r;
  assign bus.cpu_data_bus_out = dout_r;
  assign bus.cpu_data_bus_oe  = oe_r;
  assign bus.rsp_valid        = rsp_valid_r;
  assign bus.rsp_data         = rsp_data_r;
  assign bus.rsp_timeout      = rsp_timeout_r;

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bus_cycle_sequencer
//   Directed test of bus_cycle_sequencer with default parameters. Each bus
//   cycle is logged one entry per clock (entry 0 = first ACTIVE cycle) and
//   the log is compared against hand-derived timelines.
// ---------------------------------------------------------------------------
module tb_bus_cycle_sequencer;

  logic clock;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  bus_cycle_sequencer_if #(.ADDR_WIDTH(20), .DATA_WIDTH(8)) bus ();

  bus_cycle_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [2:0]  log_status [0:299];
  logic [19:0] log_addr   [0:299];
  logic        log_oe     [0:299];
  logic [7:0]  log_dout   [0:299];
  logic        log_lock   [0:299];
  logic        log_ready  [0:299];
  logic        log_rsp    [0:299];
  logic [7:0]  log_rdata  [0:299];
  logic        log_to     [0:299];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a command, wait (bounded) for cmd_ready, and pass the accept edge.
  task automatic issue(input logic [2:0] t, input logic [19:0] a, input logic [7:0] d, input logic l);
    int guard;
    guard = 0;
    bus.cmd_type    = t;
    bus.cmd_address = a;
    bus.cmd_data    = d;
    bus.cmd_lock    = l;
    bus.cmd_valid   = 1'b1;
    while (bus.cmd_ready !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    check_eq("issue_ready", 32'(bus.cmd_ready), 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // Log n cycles; raise processor_ready at entry ready_hi_at (-1 = never).
  task automatic capture(input int n, input int ready_hi_at);
    logic drop;
    for (int i = 0; i < n; i++) begin
      log_status[i] = bus.processor_status;
      log_addr[i]   = bus.cpu_address;
      log_oe[i]     = bus.cpu_data_bus_oe;
      log_dout[i]   = bus.cpu_data_bus_out;
      log_lock[i]   = bus.processor_lock_n;
      log_ready[i]  = bus.cmd_ready;
      log_rsp[i]    = bus.rsp_valid;
      log_rdata[i]  = bus.rsp_data;
      log_to[i]     = bus.rsp_timeout;
      if (i == ready_hi_at) bus.processor_ready = 1'b1;
      drop = bus.cmd_valid && bus.cmd_ready;
      tick();
      if (drop) bus.cmd_valid = 1'b0;
    end
  endtask

  function automatic int count_status(input logic [2:0] v, input int lo, input int hi);
    int c;
    c = 0;
    for (int i = lo; i <= hi; i++) if (log_status[i] == v) c++;
    return c;
  endfunction

  // sel: 0 = oe high, 1 = lock_n low, 2 = rsp_valid high, 3 = address == a
  function automatic int count_flag(input int sel, input int lo, input int hi, input logic [19:0] a);
    int c;
    c = 0;
    for (int i = lo; i <= hi; i++) begin
      case (sel)
        0:       if (log_oe[i])        c++;
        1:       if (!log_lock[i])     c++;
        2:       if (log_rsp[i])       c++;
        default: if (log_addr[i] == a) c++;
      endcase
    end
    return c;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset               = 1'b1;
    bus.cmd_valid       = 1'b0;
    bus.cmd_type        = 3'b000;
    bus.cmd_address     = 20'h00000;
    bus.cmd_data        = 8'h00;
    bus.cmd_lock        = 1'b0;
    bus.processor_ready = 1'b1;
    bus.cpu_data_bus_in = 8'h00;

    // Reset state
    tick();
    tick();
    check_eq("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check_eq("rst_status", 32'(bus.processor_status), 32'h7);
    check_eq("rst_lock_n", 32'(bus.processor_lock_n), 32'd1);
    check_eq("rst_addr", 32'(bus.cpu_address), 32'h0);
    check_eq("rst_oe", 32'(bus.cpu_data_bus_oe), 32'd0);
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    reset = 1'b0;
    tick();
    check_eq("post_rst_ready", 32'(bus.cmd_ready), 32'd1);

    // IOW 0x00061 data 0x55
    issue(3'b010, 20'h00061, 8'h55, 1'b0);
    capture(8, -1);
    check_eq("iow_status_cnt", 32'(count_status(3'b010, 0, 7)), 32'd4);
    check_eq("iow_status_hold", 32'(log_status[4]), 32'h7);
    check_eq("iow_addr_cnt", 32'(count_flag(3, 0, 7, 20'h00061)), 32'd5);
    check_eq("iow_addr_recover", 32'(log_addr[5]), 32'h0);
    check_eq("iow_oe_cnt", 32'(count_flag(0, 0, 7, 20'h0)), 32'd4);
    check_eq("iow_dout", 32'(log_dout[0]), 32'h55);
    check_eq("iow_dout_hold", 32'(log_dout[4]), 32'h0);
    check_eq("iow_rsp_valid", 32'(log_rsp[4]), 32'd1);
    check_eq("iow_rsp_cnt", 32'(count_flag(2, 0, 7, 20'h0)), 32'd1);
    check_eq("iow_rsp_data", 32'(log_rdata[4]), 32'h00);
    check_eq("iow_lock_n", 32'(count_flag(1, 0, 7, 20'h0)), 32'd0);
    check_eq("iow_ready_recover", 32'(log_ready[5]), 32'd0);
    check_eq("iow_ready_idle", 32'(log_ready[6]), 32'd1);

    // MEMR 0xB8000, ready low for three sampled edges
    bus.processor_ready = 1'b0;
    bus.cpu_data_bus_in = 8'h01;
    issue(3'b101, 20'hB8000, 8'h00, 1'b0);
    capture(10, 6);
    check_eq("memr_status_cnt", 32'(count_status(3'b101, 0, 9)), 32'd7);
    check_eq("memr_status_hold", 32'(log_status[7]), 32'h7);
    check_eq("memr_no_early_rsp", 32'(log_rsp[6]), 32'd0);
    check_eq("memr_rsp_valid", 32'(log_rsp[7]), 32'd1);
    check_eq("memr_rsp_data", 32'(log_rdata[7]), 32'h01);
    check_eq("memr_rsp_timeout", 32'(log_to[7]), 32'd0);
    check_eq("memr_oe_cnt", 32'(count_flag(0, 0, 9, 20'h0)), 32'd0);

    // MEMR with ready stuck low -> 255 wait states then timeout
    bus.processor_ready = 1'b0;
    bus.cpu_data_bus_in = 8'hAA;
    issue(3'b101, 20'hB8001, 8'h00, 1'b0);
    capture(262, -1);
    check_eq("to_status_cnt", 32'(count_status(3'b101, 0, 261)), 32'd259);
    check_eq("to_status_hold", 32'(log_status[259]), 32'h7);
    check_eq("to_rsp_valid", 32'(log_rsp[259]), 32'd1);
    check_eq("to_rsp_cnt", 32'(count_flag(2, 0, 261, 20'h0)), 32'd1);
    check_eq("to_rsp_timeout", 32'(log_to[259]), 32'd1);
    check_eq("to_rsp_data", 32'(log_rdata[259]), 32'h00);
    check_eq("to_ready_idle", 32'(log_ready[261]), 32'd1);
    bus.processor_ready = 1'b1;

    // INTA with lock, vector 0x62
    bus.cpu_data_bus_in = 8'h62;
    issue(3'b000, 20'h12345, 8'h00, 1'b1);
    capture(14, -1);
    check_eq("inta_status_cnt", 32'(count_status(3'b000, 0, 13)), 32'd8);
    check_eq("inta_gap0", 32'(log_status[4]), 32'h7);
    check_eq("inta_gap1", 32'(log_status[5]), 32'h7);
    check_eq("inta_second_start", 32'(log_status[6]), 32'h0);
    check_eq("inta_second_end", 32'(log_status[9]), 32'h0);
    check_eq("inta_gap_addr", 32'(log_addr[5]), 32'h12345);
    check_eq("inta_rsp_cnt", 32'(count_flag(2, 0, 13, 20'h0)), 32'd1);
    check_eq("inta_rsp_valid", 32'(log_rsp[10]), 32'd1);
    check_eq("inta_rsp_data", 32'(log_rdata[10]), 32'h62);
    check_eq("inta_lock_cnt", 32'(count_flag(1, 0, 13, 20'h0)), 32'd11);
    check_eq("inta_lock_release", 32'(log_lock[11]), 32'd1);

    // IOR 0x00062 followed by a queued HALT
    bus.cpu_data_bus_in = 8'h3C;
    issue(3'b001, 20'h00062, 8'h00, 1'b0);
    bus.cmd_type    = 3'b011;
    bus.cmd_address = 20'h00000;
    bus.cmd_valid   = 1'b1;
    capture(15, -1);
    check_eq("q_ior_status", 32'(count_status(3'b001, 0, 14)), 32'd4);
    check_eq("q_ior_rsp_data", 32'(log_rdata[4]), 32'h3C);
    check_eq("q_ior_rsp_valid", 32'(log_rsp[4]), 32'd1);
    check_eq("q_ready_recover", 32'(log_ready[5]), 32'd0);
    check_eq("q_ready_idle", 32'(log_ready[6]), 32'd1);
    check_eq("q_ready_busy", 32'(log_ready[7]), 32'd0);
    check_eq("q_halt_status", 32'(count_status(3'b011, 0, 14)), 32'd4);
    check_eq("q_halt_first", 32'(log_status[7]), 32'h3);
    check_eq("q_rsp_cnt", 32'(count_flag(2, 0, 14, 20'h0)), 32'd2);
    check_eq("q_halt_rsp_valid", 32'(log_rsp[11]), 32'd1);
    check_eq("q_halt_rsp_data", 32'(log_rdata[11]), 32'h00);
    check_eq("q_ready_end", 32'(log_ready[13]), 32'd1);

    // Delay cycle: ready ignored, status stays passive
    bus.processor_ready = 1'b0;
    issue(3'b111, 20'h00100, 8'h00, 1'b0);
    capture(8, -1);
    check_eq("dly_status_cnt", 32'(count_status(3'b111, 0, 7)), 32'd8);
    check_eq("dly_rsp_valid", 32'(log_rsp[4]), 32'd1);
    check_eq("dly_rsp_timeout", 32'(log_to[4]), 32'd0);
    check_eq("dly_rsp_data", 32'(log_rdata[4]), 32'h00);

    // Reset while in WAIT
    bus.processor_ready = 1'b0;
    issue(3'b101, 20'h00200, 8'h00, 1'b1);
    capture(6, -1);
    check_eq("rw_in_wait", 32'(bus.processor_status), 32'h5);
    check_eq("rw_lock_before", 32'(bus.processor_lock_n), 32'd0);
    reset = 1'b1;
    tick();
    check_eq("rw_status", 32'(bus.processor_status), 32'h7);
    check_eq("rw_lock_n", 32'(bus.processor_lock_n), 32'd1);
    check_eq("rw_addr", 32'(bus.cpu_address), 32'h0);
    check_eq("rw_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rw_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    reset = 1'b0;
    bus.processor_ready = 1'b1;
    tick();
    check_eq("rw_ready_after", 32'(bus.cmd_ready), 32'd1);
    capture(6, -1);
    check_eq("rw_no_rsp", 32'(count_flag(2, 0, 5, 20'h0)), 32'd0);
    check_eq("rw_status_idle", 32'(count_status(3'b111, 0, 5)), 32'd6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
